// File: rtl/intersection_pkg.sv
// Shared types for the intersection controller: phase encodings, lamp bundle,
// timer width and small helpers used by the RTL, board top and bench.
package intersection_pkg;

  localparam int TIMER_W = 4;

  typedef enum logic [2:0] {
    ALLRED_TO_NS = 3'd0,
    NS_GREEN     = 3'd1,
    NS_YELLOW    = 3'd2,
    ALLRED_TO_EW = 3'd3,
    EW_GREEN     = 3'd4,
    EW_YELLOW    = 3'd5,
    WALK         = 3'd6
  } state_t;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  function automatic int max_dur(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Any state not driving an approach falls through to all-red.
  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
          ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
    case (s)
      NS_GREEN:  begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
      NS_YELLOW: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
      EW_GREEN:  begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
      EW_YELLOW: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
      WALK:      l.walk = 1'b1;
      default:   ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Sensor inputs and lamp outputs of one intersection, bundled for the controller
// (master) and the board/bench side (slave).
interface intersection_controller_if;
  logic ns_car;
  logic ew_car;
  logic ped_btn;
  logic ns_red;
  logic ns_yellow;
  logic ns_green;
  logic ew_red;
  logic ew_yellow;
  logic ew_green;
  logic walk;
  logic ped_pending;

  modport master (
    input  ns_car, ew_car, ped_btn,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending
  );

  modport slave (
    output ns_car, ew_car, ped_btn,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending
  );
endinterface

// File: rtl/intersection_controller_phase_timer.sv
// Saturating cycle counter for the current phase: reads 1 in the first cycle of
// a phase, restarts to 1 on request and holds once it reaches SAT.
module phase_timer #(
  parameter int WIDTH = 4,
  parameter int SAT   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= ONE;
    end else if (restart) begin
      count_reg <= ONE;
    end else if (count_reg < SAT_V) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/intersection_controller.sv
// Actuated two-approach intersection controller with all-way pedestrian phase.
// Lamps are registered and decoded from the phase being entered.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  intersection_controller_if.master bus
);

  localparam logic [TIMER_W-1:0] GMIN_T   = TIMER_W'(GREEN_MIN);
  localparam logic [TIMER_W-1:0] GMAX_T   = TIMER_W'(GREEN_MAX);
  localparam logic [TIMER_W-1:0] YELLOW_T = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] ALLRED_T = TIMER_W'(ALLRED_TIME);
  localparam logic [TIMER_W-1:0] WALK_T   = TIMER_W'(WALK_TIME);
  // Saturate at the longest duration so every fixed-length compare stays reachable.
  localparam int TIMER_SAT = max_dur(GREEN_MAX, YELLOW_TIME, ALLRED_TIME, WALK_TIME);

  state_t             state_reg, state_next;
  logic               ped_pending_reg, ped_pending_next;
  logic               next_is_ew_reg, next_is_ew_next;
  lamps_t             lamps_reg, lamps_next;
  logic [TIMER_W-1:0] t;
  logic               restart;
  logic               ns_opp, ew_opp;

  phase_timer #(
    .WIDTH (TIMER_W),
    .SAT   (TIMER_SAT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .count   (t)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ALLRED_TO_NS;
      ped_pending_reg <= 1'b0;
      next_is_ew_reg  <= 1'b0;
      lamps_reg       <= decode_lamps(ALLRED_TO_NS);
    end else begin
      state_reg       <= state_next;
      ped_pending_reg <= ped_pending_next;
      next_is_ew_reg  <= next_is_ew_next;
      lamps_reg       <= lamps_next;
    end
  end

  assign ns_opp = bus.ew_car | ped_pending_reg;
  assign ew_opp = bus.ns_car | ped_pending_reg;

  always_comb begin
    state_next      = state_reg;
    next_is_ew_next = next_is_ew_reg;
    unique case (state_reg)
      ALLRED_TO_NS: if (t == ALLRED_T) state_next = NS_GREEN;
      ALLRED_TO_EW: if (t == ALLRED_T) state_next = EW_GREEN;
      NS_GREEN:
        if (t >= GMIN_T && ns_opp && (t >= GMAX_T || !bus.ns_car))
          state_next = NS_YELLOW;
      EW_GREEN:
        if (t >= GMIN_T && ew_opp && (t >= GMAX_T || !bus.ew_car))
          state_next = EW_YELLOW;
      NS_YELLOW:
        if (t == YELLOW_T) begin
          if (ped_pending_reg) begin
            state_next      = WALK;
            next_is_ew_next = 1'b1;
          end else begin
            state_next = ALLRED_TO_EW;
          end
        end
      EW_YELLOW:
        if (t == YELLOW_T) begin
          if (ped_pending_reg) begin
            state_next      = WALK;
            next_is_ew_next = 1'b0;
          end else begin
            state_next = ALLRED_TO_NS;
          end
        end
      WALK:
        if (t == WALK_T) state_next = next_is_ew_reg ? ALLRED_TO_EW : ALLRED_TO_NS;
      default: state_next = ALLRED_TO_NS;
    endcase
  end

  assign restart = (state_next != state_reg);

  // Entering WALK wins over a press on the same edge; presses inside WALK are dropped.
  always_comb begin
    lamps_next       = decode_lamps(state_next);
    ped_pending_next = ped_pending_reg;
    if (state_next == WALK && state_reg != WALK) begin
      ped_pending_next = 1'b0;
    end else if (bus.ped_btn && state_reg != WALK) begin
      ped_pending_next = 1'b1;
    end
  end

  assign bus.ns_red      = lamps_reg.ns_red;
  assign bus.ns_yellow   = lamps_reg.ns_yellow;
  assign bus.ns_green    = lamps_reg.ns_green;
  assign bus.ew_red      = lamps_reg.ew_red;
  assign bus.ew_yellow   = lamps_reg.ew_yellow;
  assign bus.ew_green    = lamps_reg.ew_green;
  assign bus.walk        = lamps_reg.walk;
  assign bus.ped_pending = ped_pending_reg;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed scenario bench for intersection_controller with a per-cycle lamp
// safety monitor; lamp vector is {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk}.
module tb_intersection_controller;
  import intersection_pkg::*;

  localparam logic [6:0] L_ALLRED = 7'b100_100_0;
  localparam logic [6:0] L_NSG    = 7'b001_100_0;
  localparam logic [6:0] L_NSY    = 7'b010_100_0;
  localparam logic [6:0] L_EWG    = 7'b100_001_0;
  localparam logic [6:0] L_EWY    = 7'b100_010_0;
  localparam logic [6:0] L_WALK   = 7'b100_100_1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [6:0] lamps;

  intersection_controller_if bus ();

  intersection_controller #(
    .GREEN_MIN   (4),
    .GREEN_MAX   (10),
    .YELLOW_TIME (3),
    .ALLRED_TIME (2),
    .WALK_TIME   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign lamps = {bus.ns_red, bus.ns_yellow, bus.ns_green,
                  bus.ew_red, bus.ew_yellow, bus.ew_green, bus.walk};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!(bus.ns_red || bus.ew_red) ||
        ($countones({bus.ns_red, bus.ns_yellow, bus.ns_green}) != 1) ||
        ($countones({bus.ew_red, bus.ew_yellow, bus.ew_green}) != 1)) begin
      errors++;
      $display("FAIL safety t=%0t lamps=%b required one-hot heads with a red", $time, lamps);
    end
  end

  task automatic apply_reset();
    reset       = 1'b1;
    bus.ns_car  = 1'b0;
    bus.ew_car  = 1'b0;
    bus.ped_btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts consecutive negedges showing pat, starting at the current one.
  task automatic measure(input logic [6:0] pat, output int n);
    n = 0;
    while (lamps == pat && n < 200) begin
      n++;
      @(negedge clk);
    end
    $display("phase %b lasted %0d cycles", pat, n);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    bus.ns_car = 1'b0; bus.ew_car = 1'b0; bus.ped_btn = 1'b0;
    @(negedge clk);
    checks++;
    if (lamps !== L_ALLRED) begin errors++; $display("FAIL reset_lamps got %b want %b", lamps, L_ALLRED); end
    checks++;
    if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL reset_ped got %b want 0", bus.ped_pending); end
    @(negedge clk);
    reset = 1'b0;
    measure(L_ALLRED, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL reset_allred_len got %0d want 2", n); end
    checks++;
    if (lamps !== L_NSG) begin errors++; $display("FAIL reset_first_green got %b want %b", lamps, L_NSG); end
  endtask

  task automatic test_idle();
    int g;
    g = 0;
    for (int i = 0; i < 50; i++) begin
      if (lamps == L_NSG) g++;
      @(negedge clk);
    end
    $display("idle: ns green on %0d of 50 cycles", g);
    checks++;
    if (g != 50) begin errors++; $display("FAIL idle_green got %0d want 50", g); end
  endtask

  task automatic test_ew_demand();
    int n;
    apply_reset();
    measure(L_ALLRED, n);
    bus.ew_car = 1'b1;
    measure(L_NSG, n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL demand_green_len got %0d want 4", n); end
    measure(L_NSY, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL demand_yellow_len got %0d want 3", n); end
    measure(L_ALLRED, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL demand_allred_len got %0d want 2", n); end
    checks++;
    if (lamps !== L_EWG) begin errors++; $display("FAIL demand_ew_green got %b want %b", lamps, L_EWG); end
  endtask

  task automatic test_both_cars();
    int n;
    bus.ns_car = 1'b1;
    bus.ew_car = 1'b1;
    measure(L_EWG, n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL both_ew_green_len got %0d want 10", n); end
    measure(L_EWY, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL both_ew_yellow_len got %0d want 3", n); end
    measure(L_ALLRED, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL both_allred_ns_len got %0d want 2", n); end
    measure(L_NSG, n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL both_ns_green_len got %0d want 10", n); end
    measure(L_NSY, n);
    measure(L_ALLRED, n);
    checks++;
    if (lamps !== L_EWG) begin errors++; $display("FAIL both_back_to_ew got %b want %b", lamps, L_EWG); end
    bus.ns_car = 1'b0;
    bus.ew_car = 1'b0;
  endtask

  task automatic test_ped();
    int n;
    apply_reset();
    measure(L_ALLRED, n);
    bus.ped_btn = 1'b1;
    @(negedge clk);
    bus.ped_btn = 1'b0;
    checks++;
    if (bus.ped_pending !== 1'b1) begin errors++; $display("FAIL ped_latch got %b want 1", bus.ped_pending); end
    measure(L_NSG, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL ped_green_rest got %0d want 3", n); end
    measure(L_NSY, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL ped_yellow_len got %0d want 3", n); end
    checks++;
    if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL ped_clear got %b want 0", bus.ped_pending); end
    measure(L_WALK, n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL ped_walk_len got %0d want 5", n); end
    measure(L_ALLRED, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL ped_allred_len got %0d want 2", n); end
    checks++;
    if (lamps !== L_EWG) begin errors++; $display("FAIL ped_to_ew got %b want %b", lamps, L_EWG); end
  endtask

  task automatic test_ped_hold();
    int n;
    int bad;
    apply_reset();
    measure(L_ALLRED, n);
    bus.ped_btn = 1'b1;
    @(negedge clk);
    bus.ped_btn = 1'b0;
    measure(L_NSG, n);
    measure(L_NSY, n);
    bus.ped_btn = 1'b1;
    n = 0;
    bad = 0;
    while (lamps == L_WALK && n < 200) begin
      if (bus.ped_pending !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    $display("hold: walk %0d cycles, pending seen %0d times", n, bad);
    checks++;
    if (n != 5) begin errors++; $display("FAIL hold_walk_len got %0d want 5", n); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_pending_in_walk got %0d want 0", bad); end
    checks++;
    if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL hold_pending_exit got %b want 0", bus.ped_pending); end
    @(negedge clk);
    checks++;
    if (bus.ped_pending !== 1'b1) begin errors++; $display("FAIL hold_pending_after got %b want 1", bus.ped_pending); end
    bus.ped_btn = 1'b0;
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    apply_reset();
    measure(L_ALLRED, n);
    bus.ped_btn = 1'b1;
    @(negedge clk);
    bus.ped_btn = 1'b0;
    measure(L_NSG, n);
    checks++;
    if (lamps !== L_NSY) begin errors++; $display("FAIL mid_in_yellow got %b want %b", lamps, L_NSY); end
    #2;
    reset = 1'b1;
    #1;
    $display("async reset asserted at t=%0t lamps=%b", $time, lamps);
    checks++;
    if (lamps !== L_ALLRED) begin errors++; $display("FAIL mid_reset_lamps got %b want %b", lamps, L_ALLRED); end
    checks++;
    if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL mid_reset_ped got %b want 0", bus.ped_pending); end
    @(negedge clk);
    reset = 1'b0;
    measure(L_ALLRED, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL mid_restart_allred got %0d want 2", n); end
    checks++;
    if (lamps !== L_NSG) begin errors++; $display("FAIL mid_restart_green got %b want %b", lamps, L_NSG); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_ew_demand();
    test_both_cars();
    test_ped();
    test_ped_hold();
    test_reset_mid_yellow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
